// File: rtl/mips_regfile_status.sv
// 2-read/1-write register file with hardwired r0 and a maskable 4-bit status flag register.
// Optional macro REGFILE_BYPASS_EN enables write-first forwarding on reads and status.
module mips_regfile_status #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int STATUS_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   rs_addr,
  input  logic [ADDR_WIDTH-1:0]   rt_addr,
  output logic [DATA_WIDTH-1:0]   rs_data,
  output logic [DATA_WIDTH-1:0]   rt_data,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [STATUS_WIDTH-1:0] status_we,
  input  logic [STATUS_WIDTH-1:0] status_in,
  output logic [STATUS_WIDTH-1:0] status_out
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]   regs_reg [NUM_REGS];
  logic [STATUS_WIDTH-1:0] flag_reg;
  logic                    wr_valid;

  // Writes to r0 are dropped here, so r0 stays at its reset value of zero.
  assign wr_valid = we && (wr_addr != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wr_valid) begin
      regs_reg[wr_addr] <= wr_data;
    end
  end

  generate
    for (genvar gi = 0; gi < STATUS_WIDTH; gi++) begin : g_flag
      always_ff @(posedge clk) begin
        if (reset) begin
          flag_reg[gi] <= 1'b0;
        end else if (status_we[gi]) begin
          flag_reg[gi] <= status_in[gi];
        end
      end

`ifdef REGFILE_BYPASS_EN
      assign status_out[gi] = status_we[gi] ? status_in[gi] : flag_reg[gi];
`else
      assign status_out[gi] = flag_reg[gi];
`endif
    end
  endgenerate

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] value;
    value = regs_reg[addr];
`ifdef REGFILE_BYPASS_EN
    if (wr_valid && (wr_addr == addr)) begin
      value = wr_data;
    end
`endif
    if (addr == '0) begin
      value = '0;
    end
    return value;
  endfunction

  assign rs_data = read_port(rs_addr);
  assign rt_data = read_port(rt_addr);

endmodule

// File: tb/tb_mips_regfile_status.sv
// Self-checking bench for mips_regfile_status: directed vector table, ALU-loop sequence,
// and randomized traffic against an array-based reference model.
module tb_mips_regfile_status;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam int V_BIT = 3;
  localparam int N_BIT = 2;
  localparam int Z_BIT = 1;
  localparam int C_BIT = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_addr, rt_addr, wr_addr;
  logic [31:0] rs_data, rt_data, wr_data;
  logic        we;
  logic [3:0]  status_we, status_in, status_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mips_regfile_status dut (
    .clk        (clk),
    .reset      (reset),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .we         (we),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .status_we  (status_we),
    .status_in  (status_in),
    .status_out (status_out)
  );

  typedef struct {
    bit          chk;
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [3:0]  swe;
    logic [3:0]  sin;
    logic [31:0] exp_rs;
    logic [31:0] exp_rt;
    logic [3:0]  exp_st;
  } vec_t;

  vec_t tbl[17];

  // Reference model state
  logic [31:0] mem [32];
  logic [3:0]  flags;

  function automatic vec_t mk(bit chk, logic rst, logic w, logic [4:0] wa, logic [31:0] wd,
                              logic [4:0] ra, logic [4:0] rb, logic [3:0] swe, logic [3:0] sin,
                              logic [31:0] ers, logic [31:0] ert, logic [3:0] est);
    vec_t v;
    v.chk = chk; v.rst = rst; v.we = w; v.wa = wa; v.wd = wd; v.ra = ra; v.rb = rb;
    v.swe = swe; v.sin = sin; v.exp_rs = ers; v.exp_rt = ert; v.exp_st = est;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb, input logic [3:0] swe,
                       input logic [3:0] sin);
    reset = rst; we = w; wr_addr = wa; wr_data = wd;
    rs_addr = ra; rt_addr = rb; status_we = swe; status_in = sin;
  endtask

  // Expected read value from the model, as seen before the clock edge.
  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (BYPASS && we && wr_addr != 5'd0 && wr_addr == a) return wr_data;
    return mem[a];
  endfunction

  function automatic logic [3:0] model_status();
    logic [3:0] s;
    s = flags;
    if (BYPASS) begin
      for (int i = 0; i < 4; i++) if (status_we[i]) s[i] = status_in[i];
    end
    return s;
  endfunction

  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      flags = 4'h0;
    end else begin
      if (we && wr_addr != 5'd0) mem[wr_addr] = wr_data;
      for (int i = 0; i < 4; i++) if (status_we[i]) flags[i] = status_in[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  logic [32:0] sum;
  logic [3:0]  alu_flags;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    flags = 4'h0;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 4'h0, 4'h0);

    tbl[0]  = mk(0, 1, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 4'hF, 4'hF, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 5'd0, 32'h0, 5'd5, 5'd0, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0);
    tbl[2]  = mk(1, 0, 1, 5'd1, 32'hF000000F, 5'd1, 5'd2, 4'h0, 4'h0,
                 BYPASS ? 32'hF000000F : 32'h0, 32'h0, 4'h0);
    tbl[3]  = mk(1, 0, 1, 5'd2, 32'hF00000F0, 5'd1, 5'd2, 4'h0, 4'h0,
                 32'hF000000F, BYPASS ? 32'hF00000F0 : 32'h0, 4'h0);
    tbl[4]  = mk(1, 0, 0, 5'd0, 32'h0, 5'd1, 5'd2, 4'h0, 4'h0, 32'hF000000F, 32'hF00000F0, 4'h0);
    tbl[5]  = mk(1, 0, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0);
    tbl[6]  = mk(1, 0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0);
    tbl[7]  = mk(1, 0, 1, 5'd3, 32'h11, 5'd1, 5'd2, 4'h0, 4'h0, 32'hF000000F, 32'hF00000F0, 4'h0);
    tbl[8]  = mk(1, 0, 1, 5'd3, 32'hABC, 5'd3, 5'd3, 4'h0, 4'h0,
                 BYPASS ? 32'hABC : 32'h11, BYPASS ? 32'hABC : 32'h11, 4'h0);
    tbl[9]  = mk(1, 0, 0, 5'd0, 32'h0, 5'd3, 5'd0, 4'h0, 4'h0, 32'hABC, 32'h0, 4'h0);
    tbl[10] = mk(1, 0, 0, 5'd0, 32'h0, 5'd3, 5'd0, 4'b0001, 4'hF, 32'hABC, 32'h0,
                 BYPASS ? 4'b0001 : 4'b0000);
    tbl[11] = mk(1, 0, 0, 5'd0, 32'h0, 5'd3, 5'd0, 4'h0, 4'h0, 32'hABC, 32'h0, 4'b0001);
    tbl[12] = mk(1, 0, 0, 5'd0, 32'h0, 5'd3, 5'd0, 4'h0, 4'h0, 32'hABC, 32'h0, 4'b0001);
    tbl[13] = mk(1, 0, 0, 5'd0, 32'h0, 5'd3, 5'd0, 4'h0, 4'h0, 32'hABC, 32'h0, 4'b0001);
    tbl[14] = mk(1, 0, 0, 5'd0, 32'h0, 5'd3, 5'd0, 4'h0, 4'h0, 32'hABC, 32'h0, 4'b0001);
    tbl[15] = mk(1, 1, 1, 5'd4, 32'h55, 5'd4, 5'd3, 4'h0, 4'h0,
                 BYPASS ? 32'h55 : 32'h0, 32'hABC, 4'b0001);
    tbl[16] = mk(1, 0, 0, 5'd0, 32'h0, 5'd3, 5'd4, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0);

    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].rst, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra, tbl[i].rb,
            tbl[i].swe, tbl[i].sin);
      #1;
      if (tbl[i].chk) begin
        check($sformatf("vec%0d rs_data", i), rs_data, tbl[i].exp_rs);
        check($sformatf("vec%0d rt_data", i), rt_data, tbl[i].exp_rt);
        check($sformatf("vec%0d status", i), {28'h0, status_out}, {28'h0, tbl[i].exp_st});
      end
      $display("vec%0d rst=%0b we=%0b wa=%0d wd=%h rs=%0d:%h rt=%0d:%h st=%b",
               i, reset, we, wr_addr, wr_data, rs_addr, rs_data, rt_addr, rt_data, status_out);
      tick();
    end

    // Post-edge check of the collision write
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 4'h0, 4'h0);
    tick();
    drive(1'b0, 1'b1, 5'd3, 32'hABC, 5'd3, 5'd0, 4'h0, 4'h0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 4'h0, 4'h0);
    #1 check("collision post-edge", rs_data, 32'hABC);
    $display("collision post-edge rs=%h", rs_data);

    // ALU loop: r6=0x7FFFFFFF, r7=1, ADD, capture all flags
    drive(1'b0, 1'b1, 5'd6, 32'h7FFFFFFF, 5'd0, 5'd0, 4'h0, 4'h0);
    tick();
    drive(1'b0, 1'b1, 5'd7, 32'h1, 5'd0, 5'd0, 4'h0, 4'h0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd6, 5'd7, 4'h0, 4'h0);
    #1;
    check("alu rs_data", rs_data, 32'h7FFFFFFF);
    check("alu rt_data", rt_data, 32'h1);
    sum = {1'b0, rs_data} + {1'b0, rt_data};
    alu_flags = 4'h0;
    alu_flags[C_BIT] = sum[32];
    alu_flags[Z_BIT] = (sum[31:0] == 32'h0);
    alu_flags[N_BIT] = sum[31];
    alu_flags[V_BIT] = (rs_data[31] == rt_data[31]) && (sum[31] != rs_data[31]);
    // A register write in the same cycle must not disturb the flag capture
    drive(1'b0, 1'b1, 5'd8, 32'h1234, 5'd6, 5'd7, 4'hF, alu_flags);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd6, 4'h0, 4'h0);
    #1;
    check("alu status", {28'h0, status_out}, {28'h0, 4'b1100});
    check("alu same-cycle write", rs_data, 32'h1234);
    $display("alu add status=%b r8=%h", status_out, rs_data);
    tick();

    // Randomized traffic against the reference model
    for (int c = 0; c < 300; c++) begin
      drive(($urandom_range(31) == 0), $urandom_range(1), 5'($urandom_range(31)), $urandom,
            5'($urandom_range(31)), 5'($urandom_range(31)), 4'($urandom_range(15)),
            4'($urandom_range(15)));
      if ($urandom_range(3) == 0) rt_addr = rs_addr;
      if ($urandom_range(3) == 0) rs_addr = wr_addr;
      #1;
      check($sformatf("rnd%0d rs_data", c), rs_data, model_read(rs_addr));
      check($sformatf("rnd%0d rt_data", c), rt_data, model_read(rt_addr));
      check($sformatf("rnd%0d status", c), {28'h0, status_out}, {28'h0, model_status()});
      $display("rnd%0d rst=%0b we=%0b wa=%0d rs=%0d:%h rt=%0d:%h st=%b",
               c, reset, we, wr_addr, rs_addr, rs_data, rt_addr, rt_data, status_out);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
